lcd_freq_display_module: RTL and testbench



---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_freq_display_module_if.sv | 20 ++
 rtl/lcd_write_cycle.sv | 67 ++++++
 rtl/lcd_freq_display_module.sv | 174 +++++++++++++++++
 tb/tb_lcd_freq_display_module.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types, LCD command bytes and character codes for the frequency display.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT, INIT, SNAP, L1_ADDR, L1_CHARS, L2_ADDR, L2_CHARS, CURSOR, DONE, IDLE
    } lcd_state_t;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] DISP_CUR = 8'h0F;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    // freq[0] holds freq_1 (least significant digit)
    typedef struct packed {
        logic [6:0][3:0] freq;
        logic [2:0]      digit_counter;
        logic            sel_a;
        logic            sel_b;
        logic            sel_c;
    } disp_snap_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'd0, d});
    endfunction

endpackage

// File: rtl/lcd_freq_display_module_if.sv
// Keypad-side inputs and LCD-side outputs of the frequency display block.
interface lcd_freq_display_module_if;
    logic [3:0] freq_1, freq_2, freq_3, freq_4, freq_5, freq_6, freq_7;
    logic [2:0] digit_counter;
    logic       sel_A, sel_B, sel_C;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, busy, frame_done;

    modport master (
        output freq_1, freq_2, freq_3, freq_4, freq_5, freq_6, freq_7,
        output digit_counter, sel_A, sel_B, sel_C,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, busy, frame_done
    );

    modport slave (
        input  freq_1, freq_2, freq_3, freq_4, freq_5, freq_6, freq_7,
        input  digit_counter, sel_A, sel_B, sel_C,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, busy, frame_done
    );
endinterface

// File: rtl/lcd_write_cycle.sv
// One HD44780 byte write: setup, enable strobe, hold, then post-write wait; done pulses at the end.
module lcd_write_cycle #(
    parameter int unsigned EN_CYCLES = 25,
    parameter int unsigned CMD_CYC   = 2500,
    parameter int unsigned CLEAR_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       is_clear,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       done
);
    typedef enum logic [2:0] {W_IDLE, W_SETUP, W_EN_HIGH, W_HOLD, W_WAIT} wr_state_t;

    wr_state_t   state;
    logic [31:0] cnt;
    logic        clear_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= W_IDLE;
            cnt      <= '0;
            clear_r  <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                W_IDLE: if (start) begin
                    lcd_data <= data;
                    lcd_rs   <= rs;
                    clear_r  <= is_clear;
                    state    <= W_SETUP;
                end
                W_SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= EN_CYCLES - 1;
                    state  <= W_EN_HIGH;
                end
                W_EN_HIGH: if (cnt == '0) begin
                    lcd_en <= 1'b0;
                    state  <= W_HOLD;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                W_HOLD: begin
                    cnt   <= clear_r ? CLEAR_CYC - 1 : CMD_CYC - 1;
                    state <= W_WAIT;
                end
                W_WAIT: if (cnt == '0) begin
                    done  <= 1'b1;
                    state <= W_IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/lcd_freq_display_module.sv
// Drives a 16x2 HD44780 LCD with the keypad frequency entry and A/B/C select flags.
// Define LCD_CURSOR_EN to turn on a blinking cursor parked at the next entry position.
//
// state    | meaning
// PWR_WAIT | post-reset power-up delay
// INIT     | function set, display on, clear, entry mode
// SNAP     | latch inputs so a frame never mixes old and new values
// L1_ADDR  | set DDRAM address to line 1
// L1_CHARS | write 16 characters of line 1
// L2_ADDR  | set DDRAM address to line 2
// L2_CHARS | write 16 characters of line 2
// CURSOR   | place cursor (cursor build only)
// DONE     | pulse frame_done
// IDLE     | wait for inputs to differ from the snapshot
module lcd_freq_display_module
    import lcd_pkg::*;
#(
    parameter logic [63:0] CLK_FREQ   = 64'd50000000,
    parameter int unsigned POWERUP_US = 15000,
    parameter int unsigned CMD_US     = 50,
    parameter int unsigned CLEAR_US   = 2000,
    parameter int unsigned EN_CYCLES  = 25
) (
    input logic clk,
    input logic rst,
    lcd_freq_display_module_if.slave bus
);
    localparam int unsigned POWERUP_CYC = 32'(CLK_FREQ * 64'(POWERUP_US) / 64'd1000000);
    localparam int unsigned CMD_CYC     = 32'(CLK_FREQ * 64'(CMD_US) / 64'd1000000);
    localparam int unsigned CLEAR_CYC   = 32'(CLK_FREQ * 64'(CLEAR_US) / 64'd1000000);
`ifdef LCD_CURSOR_EN
    localparam bit CURSOR_EN = 1'b1;
`else
    localparam bit CURSOR_EN = 1'b0;
`endif

    lcd_state_t  state;
    logic [31:0] pwr_cnt;
    logic [3:0]  idx;
    logic        wr_pend, wr_start, wr_rs, wr_clear, wr_done, frame_done_r;
    logic [7:0]  wr_data, nxt_data;
    logic        nxt_rs, nxt_clear;
    disp_snap_t  snap, live;

    function automatic logic [7:0] line1_char(input disp_snap_t s, input logic [3:0] col);
        logic [2:0] k;
        k = 3'(4'd9 - col);
        case (col)
            4'd0: line1_char = "F";
            4'd1: line1_char = ":";
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                if (s.digit_counter == 3'd0 && col == 4'd8) line1_char = ASCII_ZERO;
                else if (k <= s.digit_counter)              line1_char = bcd_to_ascii(s.freq[k - 3'd1]);
                else                                        line1_char = ASCII_SPACE;
            4'd10:   line1_char = "H";
            4'd11:   line1_char = "z";
            default: line1_char = ASCII_SPACE;
        endcase
    endfunction

    function automatic logic [7:0] line2_char(input disp_snap_t s, input logic [3:0] col);
        case (col)
            4'd0:    line2_char = "S";
            4'd1:    line2_char = "E";
            4'd2:    line2_char = "L";
            4'd4:    line2_char = "A";
            4'd5:    line2_char = s.sel_a ? ASCII_STAR : ASCII_DASH;
            4'd7:    line2_char = "B";
            4'd8:    line2_char = s.sel_b ? ASCII_STAR : ASCII_DASH;
            4'd10:   line2_char = "C";
            4'd11:   line2_char = s.sel_c ? ASCII_STAR : ASCII_DASH;
            default: line2_char = ASCII_SPACE;
        endcase
    endfunction

    assign live = {bus.freq_7, bus.freq_6, bus.freq_5, bus.freq_4, bus.freq_3, bus.freq_2,
                   bus.freq_1, bus.digit_counter, bus.sel_A, bus.sel_B, bus.sel_C};

    always_comb begin
        nxt_data  = LINE1;
        nxt_rs    = 1'b0;
        nxt_clear = 1'b0;
        case (state)
            INIT: case (idx[1:0])
                2'd0:    nxt_data = FUNC_SET;
                2'd1:    nxt_data = CURSOR_EN ? DISP_CUR : DISP_ON;
                2'd2:    begin nxt_data = CLEAR; nxt_clear = 1'b1; end
                default: nxt_data = ENTRY;
            endcase
            L1_CHARS: begin nxt_rs = 1'b1; nxt_data = line1_char(snap, idx); end
            L2_ADDR:  nxt_data = LINE2;
            L2_CHARS: begin nxt_rs = 1'b1; nxt_data = line2_char(snap, idx); end
            CURSOR:   nxt_data = (snap.digit_counter < 3'd7) ? LINE1 + 8'd9 : LINE1 + 8'd8;
            default:  nxt_data = LINE1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PWR_WAIT;
            pwr_cnt      <= '0;
            idx          <= '0;
            wr_pend      <= 1'b0;
            wr_start     <= 1'b0;
            wr_rs        <= 1'b0;
            wr_clear     <= 1'b0;
            wr_data      <= '0;
            snap         <= '0;
            frame_done_r <= 1'b0;
        end else begin
            wr_start     <= 1'b0;
            frame_done_r <= 1'b0;
            case (state)
                PWR_WAIT: if (pwr_cnt == POWERUP_CYC - 1) begin
                    state <= INIT;
                    idx   <= '0;
                end else begin
                    pwr_cnt <= pwr_cnt + 1'b1;
                end
                SNAP: begin
                    snap  <= live;
                    state <= L1_ADDR;
                end
                DONE: begin
                    frame_done_r <= 1'b1;
                    state        <= IDLE;
                end
                IDLE: if (live != snap) state <= SNAP;
                // every remaining state issues one byte and advances when it completes
                default: if (!wr_pend) begin
                    wr_start <= 1'b1;
                    wr_pend  <= 1'b1;
                    wr_data  <= nxt_data;
                    wr_rs    <= nxt_rs;
                    wr_clear <= nxt_clear;
                end else if (wr_done) begin
                    wr_pend <= 1'b0;
                    idx     <= idx + 1'b1;
                    case (state)
                        INIT:     if (idx == 4'd3) begin state <= SNAP; idx <= '0; end
                        L1_ADDR:  begin state <= L1_CHARS; idx <= '0; end
                        L1_CHARS: if (idx == 4'd15) state <= L2_ADDR;
                        L2_ADDR:  begin state <= L2_CHARS; idx <= '0; end
                        L2_CHARS: if (idx == 4'd15) state <= CURSOR_EN ? CURSOR : DONE;
                        CURSOR:   state <= DONE;
                        default:  state <= IDLE;
                    endcase
                end
            endcase
        end
    end

    lcd_write_cycle #(
        .EN_CYCLES (EN_CYCLES),
        .CMD_CYC   (CMD_CYC),
        .CLEAR_CYC (CLEAR_CYC)
    ) u_write (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_data),
        .is_clear (wr_clear),
        .lcd_en   (bus.lcd_en),
        .lcd_data (bus.lcd_data),
        .lcd_rs   (bus.lcd_rs),
        .done     (wr_done)
    );

    assign bus.lcd_rw     = 1'b0;
    assign bus.frame_done = frame_done_r;
    // combinational so busy rises in the very cycle the inputs diverge
    assign bus.busy       = (state != IDLE) || (live != snap);
endmodule

// File: tb/tb_lcd_freq_display_module.sv
// Directed bench for lcd_freq_display_module: captures every strobed byte and checks sequences and lines.
module tb_lcd_freq_display_module;
`ifdef LCD_CURSOR_EN
    localparam int         FRAME_LEN = 35;
    localparam logic [8:0] DISP_EXP  = 9'h00F;
`else
    localparam int         FRAME_LEN = 34;
    localparam logic [8:0] DISP_EXP  = 9'h00C;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0, n_fail = 0;
    int   cyc = 0, fd_count = 0, width_bad = 0, unstable = 0, w = 0;
    int   rel, base, rbase, fd0, n;
    logic en_prev = 1'b0;
    logic [8:0] wq[$];
    int   rise_q[$], fall_q[$];

    lcd_freq_display_module_if bus();

    lcd_freq_display_module #(
        .CLK_FREQ   (64'd1000000),
        .POWERUP_US (20),
        .CMD_US     (4),
        .CLEAR_US   (10),
        .EN_CYCLES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.frame_done) fd_count++;
        if (bus.lcd_en && !en_prev) begin
            wq.push_back({bus.lcd_rs, bus.lcd_data});
            rise_q.push_back(cyc);
            w = 1;
        end else if (bus.lcd_en) begin
            w++;
            if ({bus.lcd_rs, bus.lcd_data} !== wq[wq.size() - 1]) unstable++;
        end
        if (!bus.lcd_en && en_prev) begin
            fall_q.push_back(cyc);
            if (w != 2) width_bad++;
        end
        en_prev = bus.lcd_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int b, input logic [127:0] l1,
                             input logic [127:0] l2, input logic [7:0] cur);
        logic [127:0] g1, g2;
        logic [8:0]   t;
        int           hdr_bad;
        hdr_bad = 0;
        g1 = '0;
        g2 = '0;
        chk({tag, " bytes"}, 32'(wq.size() >= b + FRAME_LEN), 32'd1);
        if (wq.size() >= b + FRAME_LEN) begin
            for (int i = 0; i < 16; i++) begin
                t = wq[b + 1 + i];
                g1[127 - 8*i -: 8] = t[7:0];
                if (t[8] !== 1'b1) hdr_bad++;
                t = wq[b + 18 + i];
                g2[127 - 8*i -: 8] = t[7:0];
                if (t[8] !== 1'b1) hdr_bad++;
            end
            if (wq[b] !== 9'h080) hdr_bad++;
            if (wq[b + 17] !== 9'h0C0) hdr_bad++;
            chk_line({tag, " line1"}, g1, l1);
            chk_line({tag, " line2"}, g2, l2);
            chk({tag, " addr/rs errors"}, hdr_bad, 0);
`ifdef LCD_CURSOR_EN
            chk({tag, " cursor cmd"}, 32'(wq[b + 34]), {23'd0, 1'b0, cur});
`else
            chk({tag, " cursor byte unused"}, {24'd0, cur}, {24'd0, cur} & 32'hFF);
`endif
        end
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k;
        k = 0;
        while (fd_count < target && k < budget) begin @(negedge clk); k++; end
        chk("frame_done wait", 32'(fd_count >= target), 32'd1);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int k;
        k = 0;
        while (wq.size() < target && k < budget) begin @(negedge clk); k++; end
        chk("byte wait", 32'(wq.size() >= target), 32'd1);
    endtask

    task automatic chk_init(input string tag, input int b, input int rb, input int r0);
        chk({tag, " byte0"}, 32'(wq[b]),     32'h038);
        chk({tag, " byte1"}, 32'(wq[b + 1]), 32'(DISP_EXP));
        chk({tag, " byte2"}, 32'(wq[b + 2]), 32'h001);
        chk({tag, " byte3"}, 32'(wq[b + 3]), 32'h006);
        chk({tag, " powerup delay"}, 32'(rise_q[rb] - r0 >= 20), 32'd1);
        chk({tag, " clear gap extra"},
            32'((rise_q[rb + 3] - fall_q[rb + 2]) - (rise_q[rb + 2] - fall_q[rb + 1])), 32'd6);
        chk({tag, " clear gap min"}, 32'(rise_q[rb + 3] - fall_q[rb + 2] >= 12), 32'd1);
    endtask

    initial begin
        {bus.freq_7, bus.freq_6, bus.freq_5, bus.freq_4, bus.freq_3, bus.freq_2, bus.freq_1} = '0;
        bus.digit_counter = 3'd0;
        {bus.sel_A, bus.sel_B, bus.sel_C} = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst lcd_en", bus.lcd_en, 0);
        chk("rst lcd_data", bus.lcd_data, 0);
        chk("rst lcd_rs/rw", {bus.lcd_rs, bus.lcd_rw}, 0);
        chk("rst busy", bus.busy, 1);
        chk("rst frame_done", bus.frame_done, 0);

        rst = 1'b0;
        rel = cyc;
        wait_fd(1, 3000);
        chk_init("init", 0, 0, rel);
        chk_frame("frame zero", 4, "F:      0 Hz    ", "SEL A- B- C-    ", 8'h89);
        repeat (5) @(negedge clk);
        chk("frame_done count", fd_count, 1);
        chk("idle busy", bus.busy, 0);

        base = wq.size();
        fd0  = fd_count;
        bus.freq_3 = 4'd1; bus.freq_2 = 4'd2; bus.freq_1 = 4'd5;
        bus.digit_counter = 3'd3;
        bus.sel_B = 1'b1;
        #1 chk("busy on change", bus.busy, 1);
        wait_bytes(base + 6, 500);
        bus.freq_1 = 4'd6;
        wait_fd(fd0 + 2, 3000);
        repeat (600) @(negedge clk);
        chk("frames after mid change", fd_count, fd0 + 2);
        chk("no extra writes", wq.size(), base + 2 * FRAME_LEN);
        chk("busy after refresh", bus.busy, 0);
        chk_frame("frame 125", base, "F:    125 Hz    ", "SEL A- B* C-    ", 8'h89);
        chk_frame("frame 126", base + FRAME_LEN, "F:    126 Hz    ", "SEL A- B* C-    ", 8'h89);

        base = wq.size();
        fd0  = fd_count;
        bus.freq_1 = 4'hA;
        bus.digit_counter = 3'd1;
        bus.sel_A = 1'b1; bus.sel_C = 1'b1;
        wait_fd(fd0 + 1, 3000);
        chk_frame("frame qmark", base, "F:      ? Hz    ", "SEL A* B* C*    ", 8'h89);

        repeat (3) @(negedge clk);
        base = wq.size();
        fd0  = fd_count;
        {bus.freq_7, bus.freq_6, bus.freq_5, bus.freq_4, bus.freq_3, bus.freq_2, bus.freq_1} =
            {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        bus.digit_counter = 3'd7;
        {bus.sel_A, bus.sel_B, bus.sel_C} = 3'b000;
        wait_fd(fd0 + 1, 3000);
        chk_frame("frame full", base, "F:7654321 Hz    ", "SEL A- B- C-    ", 8'h88);
        chk("en width errors", width_bad, 0);
        chk("data unstable under en", unstable, 0);

        repeat (3) @(negedge clk);
        bus.freq_1 = 4'd9;
        n = 0;
        while (!bus.lcd_en && n < 500) begin @(negedge clk); n++; end
        chk("en seen before abort", bus.lcd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort lcd_en", bus.lcd_en, 0);
        chk("abort busy", bus.busy, 1);
        rst   = 1'b0;
        rel   = cyc;
        base  = wq.size();
        rbase = rise_q.size();
        fd0   = fd_count;
        wait_fd(fd0 + 1, 3000);
        chk_init("reinit", base, rbase, rel);
        chk_frame("frame after reset", base + 4, "F:7654329 Hz    ", "SEL A- B- C-    ", 8'h88);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
